// File: rtl/i2s_pkg.sv
// Shared I2S types and constants for the receive framer and the future transmitter.
package i2s_pkg;

    typedef enum logic [1:0] {
        RX_UNLOCKED = 2'd0,
        RX_SHIFT    = 2'd1,
        RX_PAD      = 2'd2
    } i2s_rx_state_t;

    localparam logic I2S_LR_LEFT  = 1'b0;
    localparam logic I2S_LR_RIGHT = 1'b1;

    localparam int unsigned I2S_SLOT_CNT_W = 6;

endpackage

// File: rtl/i2s_lrclk_edge_det.sv
// LRCLK edge detector in the bit-clock domain. The first cycle after reset only
// primes the history register, so a non-zero LRCLK level at reset release is
// not mistaken for an edge.
module i2s_lrclk_edge_det (
    input  logic i2s_bclk_i,
    input  logic sys_rst_i,
    input  logic i2s_lrclk_i,
    output logic lr_edge_c_o
);

    logic lrclk_q;
    logic primed_q;

    // LRCLK history and priming flag
    always_ff @(posedge i2s_bclk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            lrclk_q  <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            lrclk_q  <= i2s_lrclk_i;
            primed_q <= 1'b1;
        end
    end

    assign lr_edge_c_o = primed_q & (i2s_lrclk_i != lrclk_q);

endmodule

// File: rtl/i2s_rx_framer.sv
// I2S receive deframer: locks to LRCLK edges, captures I2S_WIDTH bits MSB-first
// per slot, and presents each word with its L/R tag, a valid pulse and a CDC
// toggle. Flags short slots and missing LRCLK edges.
// Build option: I2S_RX_LEFT_JUSTIFIED_EN selects left-justified framing (MSB on
// the LRCLK edge cycle) instead of the standard one-bit delay.
module i2s_rx_framer
    import i2s_pkg::*;
#(
    parameter int unsigned I2S_WIDTH  = 24,
    parameter int unsigned SLOT_WIDTH = 32
) (
    input  logic                 i2s_bclk,
    input  logic                 sys_rst,
    input  logic                 i2s_lrclk,
    input  logic                 i2s_data,
    input  logic                 rx_enable,
    output logic [I2S_WIDTH-1:0] frame_word,
    output logic                 frame_lr,
    output logic                 frame_valid,
    output logic                 frame_toggle,
    output logic                 frame_err,
    output logic                 locked
);

    localparam int unsigned BIT_CNT_W = $clog2(I2S_WIDTH);
    localparam logic [BIT_CNT_W-1:0]      BIT_LAST  = BIT_CNT_W'(I2S_WIDTH - 1);
    localparam logic [I2S_SLOT_CNT_W-1:0] SLOT_LAST = I2S_SLOT_CNT_W'(SLOT_WIDTH - 1);
    localparam logic [I2S_SLOT_CNT_W-1:0] SLOT_SAT  = '1;

    i2s_rx_state_t              state_q, state_d;
    logic [BIT_CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [I2S_WIDTH-1:0]       shift_q, shift_d;
    logic                       slot_lr_q, slot_lr_d;
    logic [I2S_SLOT_CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [I2S_WIDTH-1:0]       word_q, word_d;
    logic                       word_lr_q, word_lr_d;
    logic                       pend_q, pend_d;
    logic                       err_q, err_d;
    logic                       valid_q;
    logic                       toggle_q;
    logic                       locked_q;

    logic                       lr_edge_c;
    logic                       timeout_c;
    logic [I2S_WIDTH-1:0]       shift_in_c;
    logic [I2S_WIDTH-1:0]       start_shift_c;
    logic [BIT_CNT_W-1:0]       start_bit_cnt_c;

    i2s_lrclk_edge_det u_edge_det (
        .i2s_bclk_i  (i2s_bclk),
        .sys_rst_i   (sys_rst),
        .i2s_lrclk_i (i2s_lrclk),
        .lr_edge_c_o (lr_edge_c)
    );

    // Slot length counter, restarted by every LRCLK edge
    always_comb begin
        slot_cnt_d = slot_cnt_q;
        if (lr_edge_c) begin
            slot_cnt_d = '0;
        end else if (slot_cnt_q != SLOT_SAT) begin
            slot_cnt_d = slot_cnt_q + I2S_SLOT_CNT_W'(1);
        end
    end

    assign timeout_c  = !lr_edge_c && (slot_cnt_q == SLOT_LAST);
    assign shift_in_c = {shift_q[I2S_WIDTH-2:0], i2s_data};

    // Shifter/counter values on slot start: edge-cycle bit is the MSB or is discarded
    always_comb begin
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
        start_shift_c   = shift_in_c;
        start_bit_cnt_c = BIT_CNT_W'(1);
`else
        start_shift_c   = shift_q;
        start_bit_cnt_c = '0;
`endif
    end

    // Framer next-state and datapath
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        slot_lr_d = slot_lr_q;
        word_d    = word_q;
        word_lr_d = word_lr_q;
        pend_d    = 1'b0;
        err_d     = 1'b0;

        if (!rx_enable) begin
            state_d = RX_UNLOCKED;
        end else begin
            case (state_q)
                RX_UNLOCKED: begin
                    if (lr_edge_c) begin
                        state_d   = RX_SHIFT;
                        slot_lr_d = i2s_lrclk ? I2S_LR_RIGHT : I2S_LR_LEFT;
                        bit_cnt_d = start_bit_cnt_c;
                        shift_d   = start_shift_c;
                    end
                end
                RX_SHIFT: begin
                    if (lr_edge_c) begin
                        // Slot ended before the word completed: drop it and resync
                        err_d     = 1'b1;
                        slot_lr_d = i2s_lrclk ? I2S_LR_RIGHT : I2S_LR_LEFT;
                        bit_cnt_d = start_bit_cnt_c;
                        shift_d   = start_shift_c;
                    end else if (timeout_c) begin
                        err_d   = 1'b1;
                        state_d = RX_UNLOCKED;
                    end else begin
                        shift_d = shift_in_c;
                        if (bit_cnt_q == BIT_LAST) begin
                            word_d    = shift_in_c;
                            word_lr_d = slot_lr_q;
                            pend_d    = 1'b1;
                            state_d   = RX_PAD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
                RX_PAD: begin
                    if (lr_edge_c) begin
                        state_d   = RX_SHIFT;
                        slot_lr_d = i2s_lrclk ? I2S_LR_RIGHT : I2S_LR_LEFT;
                        bit_cnt_d = start_bit_cnt_c;
                        shift_d   = start_shift_c;
                    end else if (timeout_c) begin
                        err_d   = 1'b1;
                        state_d = RX_UNLOCKED;
                    end
                end
                default: begin
                    state_d = RX_UNLOCKED;
                end
            endcase
        end
    end

    // State, datapath and output registers
    always_ff @(posedge i2s_bclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= RX_UNLOCKED;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            slot_lr_q  <= I2S_LR_LEFT;
            slot_cnt_q <= '0;
            word_q     <= '0;
            word_lr_q  <= I2S_LR_LEFT;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            toggle_q   <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            slot_lr_q  <= slot_lr_d;
            slot_cnt_q <= slot_cnt_d;
            word_q     <= word_d;
            word_lr_q  <= word_lr_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            valid_q    <= pend_q;
            if (pend_q) begin
                toggle_q <= ~toggle_q;
            end
            locked_q   <= (state_d != RX_UNLOCKED);
        end
    end

    assign frame_word   = word_q;
    assign frame_lr     = word_lr_q;
    assign frame_valid  = valid_q;
    assign frame_toggle = toggle_q;
    assign frame_err    = err_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_rx_framer.sv
// Self-checking bench for i2s_rx_framer: an I2S source model drives slots from a
// table and hand-written sequences; expected words go to a scoreboard queue and
// are compared (word, L/R, arrival cycle, toggle) when frame_valid pulses.
module tb_i2s_rx_framer;
    import i2s_pkg::*;

    localparam int W  = 24;
    localparam int SW = 32;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam int unsigned LAT = W + 1;
`else
    localparam int unsigned LAT = W + 2;
`endif
    localparam int ACT_NONE = 0;
    localparam int ACT_RST  = 1;
    localparam int ACT_DIS  = 2;

    logic         i2s_bclk;
    logic         sys_rst;
    logic         i2s_lrclk;
    logic         i2s_data;
    logic         rx_enable;
    logic [W-1:0] frame_word;
    logic         frame_lr;
    logic         frame_valid;
    logic         frame_toggle;
    logic         frame_err;
    logic         locked;

    typedef struct packed {
        logic [W-1:0] word;
        logic         lr;
        logic [31:0]  cyc;
    } exp_t;

    typedef struct {
        int           len;
        logic [W-1:0] word;
        logic         lr;
        bit           exp_valid;
        int unsigned  exp_err;
        bit           exp_locked;
    } row_t;

    exp_t         sb[$];
    row_t         rows[10];
    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    int unsigned  cyc      = 0;
    int unsigned  err_seen = 0;
    int unsigned  exp_err_total = 0;
    logic         exp_tog  = 1'b0;
    logic [W-1:0] last_word = '0;

    i2s_rx_framer #(
        .I2S_WIDTH  (W),
        .SLOT_WIDTH (SW)
    ) dut (
        .i2s_bclk     (i2s_bclk),
        .sys_rst      (sys_rst),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_data     (i2s_data),
        .rx_enable    (rx_enable),
        .frame_word   (frame_word),
        .frame_lr     (frame_lr),
        .frame_valid  (frame_valid),
        .frame_toggle (frame_toggle),
        .frame_err    (frame_err),
        .locked       (locked)
    );

    initial i2s_bclk = 1'b0;
    always #5 i2s_bclk = ~i2s_bclk;

    always @(posedge i2s_bclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Serial bit for slot position i; unused positions carry random filler
    function automatic logic slot_bit(input int i, input logic [W-1:0] word);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
        if (i < W) return word[W-1-i];
`else
        if (i >= 1 && i <= W) return word[W-i];
`endif
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic idle(input int n, input logic lr);
        for (int i = 0; i < n; i++) begin
            @(negedge i2s_bclk);
            i2s_lrclk = lr;
            i2s_data  = 1'($urandom_range(1, 0));
        end
    endtask

    task automatic drive_slot(input int len, input logic [W-1:0] word, input logic lr,
                              input bit exp_valid, input int act_bit, input int act,
                              input bit exp_locked);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            @(negedge i2s_bclk);
            i2s_lrclk = lr;
            i2s_data  = slot_bit(i, word);
            if (i == 0 && exp_valid) begin
                e.word = word;
                e.lr   = lr;
                e.cyc  = 32'(cyc + LAT);
                sb.push_back(e);
            end
            if (act == ACT_RST && i == act_bit) begin
                sys_rst = 1'b1;
                #1;
                check("rst_mid_word",   32'(frame_word),   32'd0);
                check("rst_mid_lr",     32'(frame_lr),     32'd0);
                check("rst_mid_valid",  32'(frame_valid),  32'd0);
                check("rst_mid_toggle", 32'(frame_toggle), 32'd0);
                check("rst_mid_err",    32'(frame_err),    32'd0);
                check("rst_mid_locked", 32'(locked),       32'd0);
                sys_rst   = 1'b0;
                exp_tog   = 1'b0;
                last_word = '0;
            end
            if (act == ACT_DIS && i == act_bit) rx_enable = 1'b0;
            if (act == ACT_DIS && i == act_bit + 1) begin
                #1;
                check("dis_locked",    32'(locked),     32'd0);
                check("dis_word_hold", 32'(frame_word), 32'(last_word));
            end
        end
        if (act == ACT_DIS) rx_enable = 1'b1;
        #1;
        check("slot_end_locked", 32'(locked), 32'(exp_locked));
        check("err_count",       err_seen,    exp_err_total);
    endtask

    // Output monitor: count error pulses, score each valid word
    always @(negedge i2s_bclk) begin
        exp_t e;
        if (frame_err) err_seen++;
        if (frame_valid) begin
            exp_tog = ~exp_tog;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got word %0h lr %0b, expected no valid (cycle %0d)",
                         frame_word, frame_lr, cyc);
            end else begin
                e = sb.pop_front();
                check("valid_word",   32'(frame_word),   32'(e.word));
                check("valid_lr",     32'(frame_lr),     32'(e.lr));
                check("valid_cycle",  cyc,               e.cyc);
                check("valid_toggle", 32'(frame_toggle), 32'(exp_tog));
                last_word = e.word;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // len, word, lr, exp_valid, err pulses raised during this slot, locked at slot end
        rows[0] = '{32, 24'hA5A5A5, I2S_LR_LEFT,  1'b1, 0, 1'b1};
        rows[1] = '{32, 24'h123456, I2S_LR_RIGHT, 1'b1, 0, 1'b1};
        rows[2] = '{25, 24'h0F0F0F, I2S_LR_LEFT,  1'b1, 0, 1'b1};
        rows[3] = '{32, 24'hFFFFFF, I2S_LR_RIGHT, 1'b1, 0, 1'b1};
        rows[4] = '{32, 24'h000001, I2S_LR_LEFT,  1'b1, 0, 1'b1};
        rows[5] = '{16, 24'hABCDEF, I2S_LR_RIGHT, 1'b0, 0, 1'b1};
        rows[6] = '{32, 24'hC3C3C3, I2S_LR_LEFT,  1'b1, 1, 1'b1};
        rows[7] = '{40, 24'h5A5A5A, I2S_LR_RIGHT, 1'b1, 1, 1'b0};
        rows[8] = '{32, 24'h800001, I2S_LR_LEFT,  1'b1, 0, 1'b1};
        rows[9] = '{32, 24'h800000, I2S_LR_RIGHT, 1'b1, 0, 1'b1};

        sys_rst   = 1'b1;
        rx_enable = 1'b1;
        i2s_lrclk = 1'b1;
        i2s_data  = 1'b0;
        #2;
        check("rst_word",   32'(frame_word),   32'd0);
        check("rst_lr",     32'(frame_lr),     32'd0);
        check("rst_valid",  32'(frame_valid),  32'd0);
        check("rst_toggle", 32'(frame_toggle), 32'd0);
        check("rst_err",    32'(frame_err),    32'd0);
        check("rst_locked", 32'(locked),       32'd0);

        // LRCLK high at reset release must not look like an edge
        @(negedge i2s_bclk);
        sys_rst = 1'b0;
        idle(6, I2S_LR_RIGHT);
        #1;
        check("no_spurious_lock", 32'(locked), 32'd0);

        for (int r = 0; r < 10; r++) begin
            exp_err_total += rows[r].exp_err;
            drive_slot(rows[r].len, rows[r].word, rows[r].lr, rows[r].exp_valid,
                       -1, ACT_NONE, rows[r].exp_locked);
        end

        // Reset at bit 10 of a slot, then relock on the next edge
        drive_slot(32, 24'h777777, I2S_LR_LEFT,  1'b0, 10, ACT_RST,  1'b0);
        drive_slot(32, 24'h13579B, I2S_LR_RIGHT, 1'b1, -1, ACT_NONE, 1'b1);

        // Enable dropped at bit 5: silent drop, word held, relock after re-enable
        drive_slot(32, 24'h3C3C3C, I2S_LR_LEFT,  1'b0, 5,  ACT_DIS,  1'b0);
        drive_slot(32, 24'h0A0B0C, I2S_LR_RIGHT, 1'b1, -1, ACT_NONE, 1'b1);
        drive_slot(32, 24'hFEDCBA, I2S_LR_LEFT,  1'b1, -1, ACT_NONE, 1'b1);

        idle(8, I2S_LR_RIGHT);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("final_err_count",  err_seen,       exp_err_total);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
